fetch_pc_gen: RTL and testbench

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/fetch_pc_gen.sv | 119 +++++++++++
 tb/tb_fetch_pc_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: holds the fetch PC, presents a two-slot fetch group and
// steers the next PC from BTB predictions, execute redirects or sequential fallthrough.
module fetch_pc_gen #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 fetch_ready,
   input  logic [1:0][XLEN-1:0] btb_target_pc,
   input  logic [1:0]           btb_target_valid,
   input  logic                 redirect_valid,
   input  logic [XLEN-1:0]      redirect_pc,
   input  logic                 halt,
   output logic [1:0][XLEN-1:0] fetch_pc,
   output logic [1:0]           fetch_valid,
   output logic [31:0]          fetch_group_count,
   output logic [1:0]           debug_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   pc_plus8;
   logic [XLEN-1:0]   pc_predicted;
   logic [31:0]       count_q;
   logic              in_fetch;
   logic              slot1_ok;
   logic              accept;

   function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

   assign pc_plus4 = pc_q + XLEN'(4);
   assign pc_plus8 = pc_q + XLEN'(8);

   assign fetch_pc[0]       = pc_q;
   assign fetch_pc[1]       = pc_plus4;
   assign fetch_group_count = count_q;
   assign debug_state       = state_q;

   // Handshake: a group transfers on a clock edge where fetch_valid[0] and
   // fetch_ready are both high and no redirect is present; with fetch_ready
   // low the group is held unchanged (slot-1 valid still tracks the BTB hit).
   assign in_fetch = (state_q == ST_FETCH);
   assign slot1_ok = ~pc_q[2] & ~btb_target_valid[0];
   assign accept   = in_fetch & fetch_ready & ~redirect_valid;

   // FSM: state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next-state logic; redirect overrides everything, including halt
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = ST_FETCH;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (halt) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      fetch_valid = 2'b00;
      if (in_fetch) begin
         fetch_valid = {slot1_ok, 1'b1};
      end
   end

   // Slot-1 BTB hit only counts when slot 1 is actually part of the group.
   always_comb begin
      pc_predicted = align4(pc_plus4);
      if (btb_target_valid[0]) begin
         pc_predicted = align4(btb_target_pc[0]);
      end else if (fetch_valid[1] && btb_target_valid[1]) begin
         pc_predicted = align4(btb_target_pc[1]);
      end else if (fetch_valid[1]) begin
         pc_predicted = align4(pc_plus8);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else if (redirect_valid) begin
         pc_q <= align4(redirect_pc);
      end else if (accept) begin
         pc_q <= pc_predicted;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= 32'd0;
      end else if (accept) begin
         count_q <= count_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: driver pushes expected groups, a negedge
// monitor pops and compares every accepted group; inline checks cover stalls/halt/reset.
module tb_fetch_pc_gen;

   localparam int W = 98;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   logic             clock;
   logic             reset;
   logic             fetch_ready;
   logic [1:0][31:0] btb_target_pc;
   logic [1:0]       btb_target_valid;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             halt;
   logic [1:0][31:0] fetch_pc;
   logic [1:0]       fetch_valid;
   logic [31:0]      fetch_group_count;
   logic [1:0]       debug_state;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   fetch_pc_gen #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clock             (clock),
      .reset             (reset),
      .fetch_ready       (fetch_ready),
      .btb_target_pc     (btb_target_pc),
      .btb_target_valid  (btb_target_valid),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .halt              (halt),
      .fetch_pc          (fetch_pc),
      .fetch_valid       (fetch_valid),
      .fetch_group_count (fetch_group_count),
      .debug_state       (debug_state)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] pc0, input logic [1:0] valid, input logic [31:0] cnt);
      logic [31:0] pc1;
      pc1 = pc0 + 32'd4;
      exp_q.push_back({pc0, pc1, valid, cnt});
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      fetch_ready    = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic accept_one();
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
   endtask

   // scoreboard monitor
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clock);
         if (reset && fetch_valid[0] && fetch_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_group", {32'd0, fetch_pc[0]}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("grp_pc0",   64'(fetch_pc[0]),       64'(e[97:66]));
               check("grp_pc1",   64'(fetch_pc[1]),       64'(e[65:34]));
               check("grp_valid", 64'(fetch_valid),       64'(e[33:32]));
               check("grp_count", 64'(fetch_group_count), 64'(e[31:0]));
            end
         end
      end
   end

   initial begin
      reset            = 1'b0;
      fetch_ready      = 1'b1;
      btb_target_pc    = '0;
      btb_target_valid = 2'b00;
      redirect_valid   = 1'b0;
      redirect_pc      = 32'd0;
      halt             = 1'b0;
      #2;
      check("rst_valid", 64'(fetch_valid), 64'd0);
      check("rst_count", 64'(fetch_group_count), 64'd0);
      check("rst_pc",    64'(fetch_pc[0]), 64'd0);
      check("rst_state", 64'(debug_state), 64'(ST_IDLE));

      // sequential fetch from reset
      push_exp(32'h0,  2'b11, 32'd0);
      push_exp(32'h8,  2'b11, 32'd1);
      push_exp(32'h10, 2'b11, 32'd2);
      #10 reset = 1'b1;
      #2;
      check("bubble_valid", 64'(fetch_valid), 64'd0);
      step();
      check("bubble_state", 64'(debug_state), 64'(ST_FETCH));
      step(); step(); step();
      fetch_ready = 1'b0;
      check("seq_pc",    64'(fetch_pc[0]), 64'h18);
      check("seq_count", 64'(fetch_group_count), 64'd3);

      // slot-0 BTB hit with unaligned target
      redirect_to(32'h100);
      btb_target_valid = 2'b01;
      btb_target_pc[0] = 32'h203;
      btb_target_pc[1] = 32'hDEAD_BEEC;
      push_exp(32'h100, 2'b01, 32'd3);
      accept_one();
      btb_target_valid = 2'b00;
      check("btb0_pc",    64'(fetch_pc[0]), 64'h200);
      check("btb0_count", 64'(fetch_group_count), 64'd4);

      // pc[2]=1: single slot, slot-1 hit ignored
      redirect_to(32'h104);
      btb_target_valid = 2'b10;
      btb_target_pc[1] = 32'h500;
      push_exp(32'h104, 2'b01, 32'd4);
      accept_one();
      check("odd_pc", 64'(fetch_pc[0]), 64'h108);

      // slot-1 hit taken
      redirect_to(32'h110);
      btb_target_pc[1] = 32'h601;
      push_exp(32'h110, 2'b11, 32'd5);
      accept_one();
      btb_target_valid = 2'b00;
      check("btb1_pc",    64'(fetch_pc[0]), 64'h600);
      check("btb1_count", 64'(fetch_group_count), 64'd6);

      // redirect beats acceptance; group not counted
      redirect_to(32'h300);
      fetch_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h407;
      step();
      redirect_valid = 1'b0;
      fetch_ready    = 1'b0;
      check("redir_pc",    64'(fetch_pc[0]), 64'h404);
      check("redir_count", 64'(fetch_group_count), 64'd6);

      // PC wrap
      redirect_to(32'hFFFF_FFF8);
      push_exp(32'hFFFF_FFF8, 2'b11, 32'd6);
      accept_one();
      check("wrap8_pc", 64'(fetch_pc[0]), 64'h0);
      redirect_to(32'hFFFF_FFFC);
      push_exp(32'hFFFF_FFFC, 2'b01, 32'd7);
      accept_one();
      check("wrap4_pc", 64'(fetch_pc[0]), 64'h0);

      // halt: last group accepted, then stay halted until redirect
      redirect_to(32'h40);
      halt = 1'b1;
      push_exp(32'h40, 2'b11, 32'd8);
      fetch_ready = 1'b1;
      step();
      halt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("halt_valid", 64'(fetch_valid), 64'd0);
         check("halt_count", 64'(fetch_group_count), 64'd9);
      end
      check("halt_state", 64'(debug_state), 64'(ST_HALTED));
      redirect_to(32'h80);
      check("resume_pc",    64'(fetch_pc[0]), 64'h80);
      check("resume_valid", 64'(fetch_valid), 64'd3);

      // stall then async reset mid-stall
      redirect_to(32'h20);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_pc",    64'(fetch_pc[0]), 64'h20);
         check("stall_count", 64'(fetch_group_count), 64'd9);
         check("stall_valid", 64'(fetch_valid), 64'd3);
      end
      #2 reset = 1'b0;
      #1;
      check("arst_pc",    64'(fetch_pc[0]), 64'h0);
      check("arst_count", 64'(fetch_group_count), 64'd0);
      check("arst_valid", 64'(fetch_valid), 64'd0);
      step();
      #1 reset = 1'b1;
      step();
      check("arst_fetch", 64'(debug_state), 64'(ST_FETCH));
      push_exp(32'h0, 2'b11, 32'd0);
      accept_one();
      check("post_pc",    64'(fetch_pc[0]), 64'h8);
      check("post_count", 64'(fetch_group_count), 64'd1);

      step();
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
